// File: rtl/multi_channel_debouncer_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Optional DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser per channel.
package debounce_pkg;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_QUALIFY = 1'b1
  } db_state_e;

  // Bits needed to count 0 .. value-1.
  function automatic int db_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: optional synchroniser, 2-state qualify FSM, counter,
// filtered output register and registered rise/fall pulses. Macro: DEBOUNCE_SYNC_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 100,
  parameter logic RST_LEVEL     = 1'b0,
  parameter int   CNT_W         = db_clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic noisy_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic state_dbg_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             sample;
  logic             accept;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{RST_LEVEL}};
    else        sync_q <= {sync_q[0], noisy_i};
  end

  assign sample = sync_q[1];
`else
  assign sample = noisy_i;
`endif

  // The differing sample that completes the count is the accepting one.
  assign accept = (state_q == DB_QUALIFY) && (sample != out_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      out_q   <= RST_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      DB_STABLE: begin
        if (sample != out_q) begin
          state_d = DB_QUALIFY;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_QUALIFY: begin
        if ((sample == out_q) || accept) begin
          state_d = DB_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DB_STABLE;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (accept) begin
      out_d  = sample;
      rise_d = sample;
      fall_d = ~sample;
    end
  end

  assign out_o       = out_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign state_dbg_o = state_q;

endmodule

// File: rtl/multi_channel_debouncer.sv
// N independent debounce channels with rise/fall pulses and bouncing status.
// Macro: DEBOUNCE_SYNC_EN enables a 2-flop synchroniser in every channel.
module multi_channel_debouncer
  import debounce_pkg::*;
#(
  parameter int   NUM_CH        = 4,
  parameter int   STABLE_CYCLES = 100,
  parameter logic RST_LEVEL     = 1'b0,
  parameter int   CNT_W         = db_clog2(STABLE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] noisy_in,
  output logic [NUM_CH-1:0] debouncer_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] bouncing
);

  logic [NUM_CH-1:0] state_dbg;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .RST_LEVEL    (RST_LEVEL),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .noisy_i    (noisy_in[g]),
      .out_o      (debouncer_out[g]),
      .rise_o     (rise_pulse[g]),
      .fall_o     (fall_pulse[g]),
      .state_dbg_o(state_dbg[g])
    );
  end

  // Registered state doubles as the bouncing flag (QUALIFY encodes as 1).
  assign bouncing = state_dbg;

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Directed + randomised bench for multi_channel_debouncer (NUM_CH=4, STABLE_CYCLES=8).
// The reference model accepts a level once the last STABLE_CYCLES samples all differ.
module tb_multi_channel_debouncer;

  localparam int NCH = 4;
  localparam int SC  = 8;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NCH-1:0] noisy_in = '0;
  logic [NCH-1:0] debouncer_out, rise_pulse, fall_pulse, bouncing;

  int tests_run = 0;
  int tests_failed = 0;

  multi_channel_debouncer #(
    .NUM_CH       (NCH),
    .STABLE_CYCLES(SC),
    .RST_LEVEL    (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .noisy_in     (noisy_in),
    .debouncer_out(debouncer_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .bouncing     (bouncing)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [NCH-1:0] hist_q[$];
  logic [NCH-1:0] m_out, m_rise, m_fall, m_bnc;
  logic [NCH-1:0] m_s1, m_s2;

  task automatic model_reset();
    hist_q.delete();
    m_out  = '0;
    m_rise = '0;
    m_fall = '0;
    m_bnc  = '0;
    m_s1   = '0;
    m_s2   = '0;
  endtask

  task automatic model_edge(input logic [NCH-1:0] raw);
    logic [NCH-1:0] smp;
    int run;
    if (LAT == 2) begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
    end else begin
      smp = raw;
    end
    hist_q.push_back(smp);
    if (hist_q.size() > 64) void'(hist_q.pop_front());
    m_rise = '0;
    m_fall = '0;
    m_bnc  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      run = 0;
      for (int i = hist_q.size() - 1; i >= 0; i--) begin
        if (run >= SC || hist_q[i][ch] == m_out[ch]) break;
        run++;
      end
      if (run == SC) begin
        m_out[ch] = ~m_out[ch];
        if (m_out[ch]) m_rise[ch] = 1'b1;
        else           m_fall[ch] = 1'b1;
      end else if (run > 0) begin
        m_bnc[ch] = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check4(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs == exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check4("out", debouncer_out, m_out);
    check4("rise", rise_pulse, m_rise);
    check4("fall", fall_pulse, m_fall);
    check4("bouncing", bouncing, m_bnc);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; drives one sample, advances one edge, checks at the next negedge.
  task automatic tick(input logic [NCH-1:0] v);
    noisy_in = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
    check_model();
  endtask

  // Asserts reset between edges and checks that outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check4({tag, "_out"}, debouncer_out, '0);
    check4({tag, "_rise"}, rise_pulse, '0);
    check4({tag, "_fall"}, fall_pulse, '0);
    check4({tag, "_bnc"}, bouncing, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int lat;
    logic [NCH-1:0] cur;

    model_reset();
    @(negedge clk);
    async_reset("rst_init");
    for (int k = 0; k < 20; k++) tick('0);

    // Clean accept on ch0.
    for (int k = 1; k <= SC + LAT; k++) begin
      tick(4'b0001);
      if (k < SC + LAT) check4("accept_hold", debouncer_out & 4'b0001, 4'b0000);
      if (k > LAT && k < SC + LAT) check4("accept_bnc", bouncing & 4'b0001, 4'b0001);
      if (k == SC + LAT) begin
        check4("accept_out", debouncer_out & 4'b0001, 4'b0001);
        check4("accept_rise", rise_pulse & 4'b0001, 4'b0001);
      end
    end
    tick(4'b0001);
    check4("accept_rise_1cyc", rise_pulse & 4'b0001, 4'b0000);

    // Rejected glitch on ch1: seven edges high is one short.
    for (int k = 0; k < SC - 1; k++) tick(4'b0011);
    for (int k = 0; k < 4; k++) tick(4'b0001);
    check4("glitch_out", debouncer_out & 4'b0010, 4'b0000);
    check4("glitch_bnc", bouncing & 4'b0010, 4'b0000);

    // Bounce train on ch2, then steady high.
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick((k % 2 == 0) ? 4'b0101 : 4'b0001);
      if (rise_pulse[2]) cnt++;
    end
    for (int k = 0; k < SC + LAT + 4; k++) begin
      tick(4'b0101);
      if (rise_pulse[2]) cnt++;
    end
    check_int("bounce_rise_count", cnt, 1);
    check4("bounce_out", debouncer_out, 4'b0101);

    // ch0 falls while ch3 rises on the same edge.
    for (int k = 1; k <= SC + LAT; k++) begin
      tick(4'b1100);
      if (k == SC + LAT) begin
        check4("simul_fall", fall_pulse, 4'b0001);
        check4("simul_rise", rise_pulse, 4'b1000);
        check4("simul_out", debouncer_out, 4'b1100);
      end
    end

    // Randomised sequence with sticky levels so that some changes qualify.
    cur = noisy_in;
    for (int k = 0; k < 400; k++) begin
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 9) < 2) cur[ch] = ~cur[ch];
      tick(cur);
    end
    async_reset("rst_random");
    for (int k = 0; k < 12; k++) tick('0);

    // Reset in the middle of qualification discards the partial count.
    for (int k = 0; k < 5; k++) tick(4'b0001);
    check4("pre_rst_bnc", bouncing & 4'b0001, 4'b0001);
    async_reset("rst_qualify");
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(4'b0001);
      if (lat < 0 && debouncer_out[0]) lat = k;
    end
    check_int("rst_qualify_latency", lat, SC + LAT);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
